fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-low.
- redirect_valid  in  1  branch/jump redirect from the pipeline (jal/jalr/taken branch).
- redirect_pc  in  32  new fetch address.
- imem_req_valid  out  1  instruction-memory request.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  byte address of the request.
- imem_rsp_valid  in  1  response beat; responses return in request order, latency of 1 or more cycles.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  head entry is available to decode.
- if_ready  in  1  decode accepts (low = stall).
- if_pc  out  32  PC of the head entry.
- if_instr  out  32  instruction of the head entry.

Function
REQ-004 SHALL keep fetch_pc; imem_addr = fetch_pc; fetch_pc advances by 4 on each request fire (imem_req_valid & imem_req_ready).
REQ-005 SHALL assert imem_req_valid only when reset is high, redirect_valid is low, and count + outstanding < DEPTH.
REQ-006 SHALL count outstanding: +1 on request fire, -1 on each imem_rsp_valid, including dropped responses.
REQ-007 SHALL keep rsp_pc; an accepted, non-dropped response pushes {rsp_pc, imem_rsp_data} into the FIFO, then rsp_pc advances by 4.
REQ-008 SHALL drive if_valid = (count != 0) & ~redirect_valid; if_pc and if_instr come from the head entry; pop on if_valid & if_ready.
REQ-009 SHALL hold the head entry stable while if_valid & ~if_ready.
REQ-010 SHALL allow push and pop in the same cycle at any occupancy, including full; count stays unchanged.
REQ-011 SHALL never overflow: because of the reservation rule in REQ-005, a response always has a free slot.
REQ-012 On redirect_valid, the next cycle SHALL have:
- count = 0 and FIFO pointers cleared;
- fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00};
- drop_cnt = outstanding - imem_rsp_valid, saturating at 0.
REQ-013 A response arriving in the redirect cycle SHALL be discarded.
REQ-014 A pop in the redirect cycle SHALL be ignored, since if_valid is masked low.
REQ-015 While drop_cnt > 0, each imem_rsp_valid SHALL decrement drop_cnt and be discarded; there is no push and rsp_pc is unchanged.
REQ-016 Back-to-back redirects SHALL each reload the PCs; drop_cnt is recomputed per REQ-012.
REQ-017 fetch_pc and rsp_pc SHALL wrap modulo 2^32.
REQ-018 count, outstanding and drop_cnt SHALL be $clog2(DEPTH)+1 bits wide.
REQ-019 Steady-state throughput SHALL be 1 instruction/cycle, given a 1-cycle memory and if_ready held high.
REQ-020 First-response-to-if_valid latency SHALL be 1 cycle (the response is registered into the FIFO).

Reset
REQ-021 While reset is low, at the clock edge:
- fetch_pc = rsp_pc = RESET_PC;
- count = outstanding = drop_cnt = 0;
- FIFO pointers = 0.
REQ-022 While reset is low, outputs SHALL be imem_req_valid = 0 and if_valid = 0; if_pc and if_instr read 0.
REQ-023 Reset asserted mid-operation SHALL abandon in-flight requests; any responses arriving after reset releases are the memory's responsibility to suppress.

Structure
REQ-024 Package riscv_fetch_pkg SHALL hold:
- fetch_entry_t struct {pc[31:0], instr[31:0]};
- PC_STEP = 4;
- DEFAULT_DEPTH = 4.
REQ-025 Storage SHALL be a sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, clear, count, head; no bypass.
REQ-026 Issue, drop and PC logic SHALL stay in fetch_queue; no latches, no combinational paths from imem_rsp_* to imem_req_valid.

Verification
REQ-027 Reset release, 1-cycle memory, if_ready = 1 -> addresses 0x0, 0x4, 0x8…; if_pc sequence 0x0, 0x4, 0x8 with matching instructions; if_valid first high 2 cycles after first fire.
REQ-028 if_ready = 0 for 10 cycles -> exactly 4 entries buffered; imem_req_valid low once count + outstanding = 4; head stays at PC 0x0.
REQ-029 Memory latency 3, 3 requests outstanding, redirect_pc = 0x103 -> 3 stale responses dropped; next imem_addr = 0x100; first if_pc = 0x100.
REQ-030 Redirect in the same cycle as a pop and a response -> neither counted; count = 0 next cycle; drop_cnt = outstanding - 1.
REQ-031 Full queue, pop and push in the same cycle -> count stays 4; order preserved.
REQ-032 fetch_pc = 0xFFFF_FFFC -> next imem_addr = 0x0000_0000; reset pulled low mid-burst -> all counters 0; imem_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package riscv_fetch_pkg;

  localparam int PC_STEP       = 4;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Push/pop/clear bus between the fetch control logic and its entry FIFO.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import riscv_fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic         push;
  logic         pop;
  logic         clear;
  fetch_entry_t push_data;
  fetch_entry_t head;
  logic [CW-1:0] count;

  modport master (
    output push, pop, clear, push_data,
    input  head, count
  );

  modport slave (
    input  push, pop, clear, push_data,
    output head, count
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries; head is read straight from storage, no bypass.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  fetch_queue_if.slave fif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = fif.push;
  assign w_pop  = fif.pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (fif.clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // When full, a simultaneous pop frees the slot the write lands in.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= fif.push_data;
  end

  assign fif.head  = r_mem[r_rd_ptr];
  assign fif.count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tracks in-flight
// requests, drops stale responses after a redirect and buffers results.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic          w_fire;
  logic          w_dropping;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_after_rsp;
  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] w_drop_next;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .fif   (fq)
  );

  assign w_count = fq.count;

  // Slots are reserved at issue time, so a returning response always fits.
  assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req_valid = reset & ~redirect_valid & (w_inflight < (CW+1)'(DEPTH));
  assign imem_addr      = r_fetch_pc;
  assign w_fire         = imem_req_valid & imem_req_ready;

  assign w_dropping = (r_drop_cnt != '0);
  assign w_push     = imem_rsp_valid & ~redirect_valid & ~w_dropping;

  assign if_valid = reset & (w_count != '0) & ~redirect_valid;
  assign w_pop    = if_valid & if_ready;
  assign if_pc    = reset ? fq.head.pc    : 32'h0;
  assign if_instr = reset ? fq.head.instr : 32'h0;

  assign fq.push      = w_push;
  assign fq.pop       = w_pop;
  assign fq.clear     = redirect_valid;
  assign fq.push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

  always_comb begin
    w_out_after_rsp = r_outstanding;
    if (imem_rsp_valid && (r_outstanding != '0)) w_out_after_rsp = r_outstanding - CW'(1);
    w_outstanding_next = w_out_after_rsp + CW'(w_fire);

    // Everything still in flight after this cycle's response belongs to the old path.
    w_drop_next = r_drop_cnt;
    if (redirect_valid)                    w_drop_next = w_out_after_rsp;
    else if (imem_rsp_valid && w_dropping) w_drop_next = r_drop_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_next;
      if (redirect_valid) begin
        r_fetch_pc <= align_pc(redirect_pc);
        r_rsp_pc   <= align_pc(redirect_pc);
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 32'(PC_STEP);
        if (w_push) r_rsp_pc   <= r_rsp_pc + 32'(PC_STEP);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory model of configurable latency.
module tb_fetch_queue;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fifo_rst = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mem_lat = 1;

  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  fetch_queue_if #(.DEPTH(4)) fif_tb ();
  fetch_fifo #(.DEPTH(4)) u_fifo_tb (.clk(clk), .reset(fifo_rst), .fif(fif_tb));

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model: responses in order, mem_lat cycles after the request fires.
  always @(negedge clk) begin
    if (!reset) begin
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_addr);
        q_due.push_back(cyc + mem_lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    repeat (2) tick();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    tests++; if (dut.w_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", dut.w_count); end
    tests++; if (dut.r_outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", dut.r_outstanding); end
    tests++; if (dut.r_drop_cnt !== 3'd0) begin fails++; $display("FAIL reset_drop: got %0d want 0", dut.r_drop_cnt); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    int first_fire;
    int first_valid;
    int late_pops;
    exp_addr = 32'h0; exp_pc = 32'h0;
    first_fire = -1; first_valid = -1; late_pops = 0;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1; reset = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_req_ready) begin
        if (first_fire < 0) first_fire = i;
        tests++; if (imem_addr !== exp_addr) begin fails++; $display("FAIL stream_addr: got %h want %h", imem_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (if_valid && if_ready) begin
        if (first_valid < 0) first_valid = i;
        $display("[TB] pop pc=%h instr=%h", if_pc, if_instr);
        tests++; if (if_pc !== exp_pc) begin fails++; $display("FAIL stream_pc: got %h want %h", if_pc, exp_pc); end
        tests++; if (if_instr !== instr_of(exp_pc)) begin fails++; $display("FAIL stream_instr: got %h want %h", if_instr, instr_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        if (i >= 10) late_pops++;
      end
      tick();
    end
    tests++; if (exp_addr !== 32'd80) begin fails++; $display("FAIL stream_fires: got %0d want 20", exp_addr / 4); end
    tests++; if (first_valid - first_fire != 2) begin fails++; $display("FAIL stream_latency: got %0d want 2", first_valid - first_fire); end
    tests++; if (late_pops != 10) begin fails++; $display("FAIL stream_throughput: got %0d want 10", late_pops); end
  endtask

  task automatic test_stall();
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0; reset = 1'b1;
    repeat (10) tick();
    tests++; if (dut.w_count !== 3'd4) begin fails++; $display("FAIL stall_count: got %0d want 4", dut.w_count); end
    tests++; if (dut.r_outstanding !== 3'd0) begin fails++; $display("FAIL stall_outstanding: got %0d want 0", dut.r_outstanding); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL stall_if_valid: got %b want 1", if_valid); end
    tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL stall_head_pc: got %h want 0", if_pc); end
    tests++; if (if_instr !== instr_of(32'h0)) begin fails++; $display("FAIL stall_head_instr: got %h want %h", if_instr, instr_of(32'h0)); end
    if_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++; if (!if_valid || if_pc !== 32'(4 * k)) begin fails++; $display("FAIL stall_drain: got v=%b pc=%h want pc %h", if_valid, if_pc, 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_redirect_stale();
    int fires;
    int got;
    fires = 0; got = 0;
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1; reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (imem_req_valid) fires++;
      tick();
    end
    tests++; if (fires != 3) begin fails++; $display("FAIL stale_fires: got %0d want 3", fires); end
    tests++; if (dut.r_outstanding !== 3'd3) begin fails++; $display("FAIL stale_outstanding: got %0d want 3", dut.r_outstanding); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; imem_req_ready = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stale_req_mask: got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL stale_addr: got %h want 00000100", imem_addr); end
    tests++; if (dut.r_drop_cnt !== 3'd2) begin fails++; $display("FAIL stale_drop: got %0d want 2", dut.r_drop_cnt); end
    tests++; if (dut.w_count !== 3'd0) begin fails++; $display("FAIL stale_count: got %0d want 0", dut.w_count); end
    tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL stale_reissue: got %b want 1", imem_req_valid); end
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (if_valid) begin
        got = 1;
        tests++; if (if_pc !== 32'h100) begin fails++; $display("FAIL stale_first_pc: got %h want 00000100", if_pc); end
        tests++; if (if_instr !== instr_of(32'h100)) begin fails++; $display("FAIL stale_first_instr: got %h want %h", if_instr, instr_of(32'h100)); end
      end else begin
        tick();
      end
    end
    tests++; if (got != 1) begin fails++; $display("FAIL stale_timeout: got no if_valid want one within 20 cycles"); end
    tests++; if (dut.r_drop_cnt !== 3'd0) begin fails++; $display("FAIL stale_drop_done: got %0d want 0", dut.r_drop_cnt); end
  endtask

  task automatic test_redirect_pop_rsp();
    int got;
    got = 0;
    do_reset();
    mem_lat = 2; imem_req_ready = 1'b1; if_ready = 1'b1; reset = 1'b1;
    repeat (6) tick();
    tests++; if (dut.w_count !== 3'd1 || dut.r_outstanding !== 3'd2) begin fails++; $display("FAIL same_cycle_pre: got count=%0d out=%0d want 1/2", dut.w_count, dut.r_outstanding); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL same_cycle_if_mask: got %b want 0", if_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    tests++; if (dut.w_count !== 3'd0) begin fails++; $display("FAIL same_cycle_count: got %0d want 0", dut.w_count); end
    tests++; if (dut.r_drop_cnt !== 3'd1) begin fails++; $display("FAIL same_cycle_drop: got %0d want 1", dut.r_drop_cnt); end
    tests++; if (dut.r_outstanding !== 3'd1) begin fails++; $display("FAIL same_cycle_out: got %0d want 1", dut.r_outstanding); end
    tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL same_cycle_addr: got %h want 00000200", imem_addr); end
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (if_valid) begin
        got = 1;
        tests++; if (if_pc !== 32'h200) begin fails++; $display("FAIL same_cycle_first_pc: got %h want 00000200", if_pc); end
      end else begin
        tick();
      end
    end
    tests++; if (got != 1) begin fails++; $display("FAIL same_cycle_timeout: got no if_valid want one within 20 cycles"); end
  endtask

  task automatic test_fifo_full();
    fifo_rst = 1'b0; fif_tb.push = 1'b0; fif_tb.pop = 1'b0; fif_tb.clear = 1'b0;
    tick();
    fifo_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fif_tb.push = 1'b1;
      fif_tb.push_data = '{pc: 32'h1000 + 32'(4 * k), instr: instr_of(32'h1000 + 32'(4 * k))};
      tick();
    end
    fif_tb.push = 1'b0;
    #1;
    tests++; if (fif_tb.count !== 3'd4) begin fails++; $display("FAIL fifo_fill_count: got %0d want 4", fif_tb.count); end
    fif_tb.push = 1'b1; fif_tb.pop = 1'b1;
    fif_tb.push_data = '{pc: 32'h1010, instr: instr_of(32'h1010)};
    tick();
    fif_tb.push = 1'b0; fif_tb.pop = 1'b0;
    #1;
    tests++; if (fif_tb.count !== 3'd4) begin fails++; $display("FAIL fifo_full_pushpop_count: got %0d want 4", fif_tb.count); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (fif_tb.head.pc !== 32'h1004 + 32'(4 * k) || fif_tb.head.instr !== instr_of(32'h1004 + 32'(4 * k))) begin
        fails++; $display("FAIL fifo_order: got %h want %h", fif_tb.head.pc, 32'h1004 + 32'(4 * k));
      end
      fif_tb.pop = 1'b1;
      tick();
      fif_tb.pop = 1'b0;
    end
    tests++; if (fif_tb.count !== 3'd0) begin fails++; $display("FAIL fifo_empty_count: got %0d want 0", fif_tb.count); end
    fif_tb.push = 1'b1;
    tick();
    fif_tb.push = 1'b0; fif_tb.clear = 1'b1;
    tick();
    fif_tb.clear = 1'b0;
    tests++; if (fif_tb.count !== 3'd0) begin fails++; $display("FAIL fifo_clear: got %0d want 0", fif_tb.count); end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    n = 0;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1; reset = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_align: got %h want fffffffc", imem_addr); end
    tick();
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
    for (int i = 0; i < 10 && n < 2; i++) begin
      if (if_valid) begin
        tests++; if (if_pc !== ((n == 0) ? 32'hFFFF_FFFC : 32'h0)) begin fails++; $display("FAIL wrap_if_pc: got %h want %h", if_pc, (n == 0) ? 32'hFFFF_FFFC : 32'h0); end
        n++;
      end
      tick();
    end
    tests++; if (n != 2) begin fails++; $display("FAIL wrap_timeout: got %0d pops want 2", n); end
    reset = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin
      fails++; $display("FAIL midreset_outputs: got req=%b v=%b pc=%h want 0/0/0", imem_req_valid, if_valid, if_pc);
    end
    tick();
    tests++; if (dut.w_count !== 3'd0 || dut.r_outstanding !== 3'd0 || dut.r_drop_cnt !== 3'd0) begin
      fails++; $display("FAIL midreset_counters: got c=%0d o=%0d d=%0d want 0", dut.w_count, dut.r_outstanding, dut.r_drop_cnt);
    end
    tests++; if (imem_addr !== 32'h0 || dut.r_rsp_pc !== 32'h0) begin fails++; $display("FAIL midreset_pc: got %h/%h want 0", imem_addr, dut.r_rsp_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fif_tb.push = 1'b0;
    fif_tb.pop = 1'b0;
    fif_tb.clear = 1'b0;
    fif_tb.push_data = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_pop_rsp();
    test_fifo_full();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
